reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: Reg_bank

Interface
REQ-001 SHALL have no parameters; register count 16, data width 32 and address width 4 are fixed.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 we3  input  1  write enable for write port 3.
REQ-005 ra1  input  4  read address, port 1.
REQ-006 ra2  input  4  read address, port 2.
REQ-007 wa3  input  4  write address, port 3.
REQ-008 wev  input  128  vector side-band bus, reserved in this revision.
REQ-009 wd3  input  32  write data, port 3.
REQ-010 r_vga  input  32  externally supplied value presented as register 15 (VGA/status word).
REQ-011 rd1  output  32  read data, port 1.
REQ-012 rd2  output  32  read data, port 2.

Function
REQ-013 SHALL hold 15 storage registers R0..R14, each 32 bits; address 15 SHALL have no storage.
REQ-014 Read ports SHALL be combinational, zero latency: rdN = R[raN] for raN 0..14; rdN = r_vga for raN = 15.
REQ-015 rd1 and rd2 SHALL be independent; equal addresses on both ports return identical data.
REQ-016 When we3=1, rst=0 and wa3 in 0..14, R[wa3] SHALL load wd3 on the rising clk edge; no other register changes.
REQ-017 When we3=1 and wa3 = 15, the write SHALL be discarded; no state changes.
REQ-018 When we3=0, no register SHALL change regardless of wa3/wd3.
REQ-019 Read-during-write to the same address SHALL return the old value until the edge, then the new value combinationally after it (no write-through bypass).
REQ-020 r_vga changes SHALL propagate to any port addressing 15 combinationally, with no clock.
REQ-021 wev SHALL not affect any register or output; it is accepted and ignored.
REQ-022 Outputs SHALL never be X/Z once rst has been asserted at least once.
REQ-023 Only one write per cycle; no write collision handling exists or is needed.

Reset
REQ-024 rst=1 SHALL clear R0..R14 to 32'h0000_0000 immediately, independent of clk.
REQ-025 While rst=1 writes SHALL be blocked; reads SHALL return 0 for addresses 0..14 and r_vga for 15.
REQ-026 Reset asserted mid-write (same edge as we3=1) SHALL win; the register stays 0.
REQ-027 After rst deasserts, the first rising edge with we3=1 SHALL perform a normal write.

Verification
REQ-028 Assert rst, ra1=ra2=0, r_vga=0 -> rd1=rd2=0 before any clock edge; ra1=ra2=1 -> rd1=rd2=0.
REQ-029 rst=0, we3=1, wa3=0, wd3=32'hFF, one rising edge -> with ra1=0, rd1=32'h0000_00FF; rd2 (ra2=1) stays 0.
REQ-030 we3=0, wa3=15, wd3=32'hFF, edge -> R0 still 32'hFF; reading 15 returns r_vga (0); then we3=1, wa3=15, wd3=32'hFF, edge -> reading 15 still returns r_vga, R0..R14 unchanged.
REQ-031 Set r_vga=32'hDEAD_BEEF with ra2=15, no clock -> rd2=32'hDEAD_BEEF within the same time step.
REQ-032 Write 32'h1234_5678 to R14, then toggle wev to all-ones and pulse rst between edges -> rd1(ra1=14) returns 32'h1234_5678 before rst, 0 immediately on rst assertion, wev has no effect.
REQ-033 Write all 15 registers with value = address+1, read each on both ports -> rdN = raN+1 for 0..14, r_vga for 15.

Source files
------------

// File: rtl/reg_bank.sv
// reg_bank: three-port register file.
//   15 storage registers R0..R14, 32 bits each. Address 15 has no storage and
//   reads back the externally supplied r_vga word.
//   Two combinational read ports (ra1/rd1, ra2/rd2). One synchronous write
//   port (we3/wa3/wd3) that updates on the rising clk edge. Writes to
//   address 15 are dropped.
//   rst is asynchronous and active-high. It clears R0..R14 and blocks writes
//   while it is held.
//   wev is a reserved side-band bus. It is accepted and has no effect.
//
// Ports:
//   clk   in   1   clock
//   rst   in   1   async active-high reset
//   we3   in   1   write enable
//   ra1   in   4   read address, port 1
//   ra2   in   4   read address, port 2
//   wa3   in   4   write address
//   wev   in 128   reserved, ignored
//   wd3   in  32   write data
//   r_vga in  32   value returned for address 15
//   rd1   out 32   read data, port 1
//   rd2   out 32   read data, port 2
module reg_bank (
    input  logic        clk,
    input  logic        rst,
    input  logic        we3,
    input  logic [3:0]  ra1,
    input  logic [3:0]  ra2,
    input  logic [3:0]  wa3,
    input  logic [127:0] wev,
    input  logic [31:0] wd3,
    input  logic [31:0] r_vga,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    localparam int DATA_W = 32;
    localparam int NREGS  = 15;
    localparam logic [3:0] VGA_ADDR = 4'hF;

    logic [DATA_W-1:0] regs [0:NREGS-1];

    // Reserved bus: folded into a deliberately unused net so it stays
    // visibly disconnected from the datapath.
    logic unused_wev;
    assign unused_wev = ^wev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we3 && (wa3 != VGA_ADDR)) begin
            regs[wa3] <= wd3;
        end
    end

    // No write-through bypass: reads always see the currently stored value.
    always_comb begin
        rd1 = (ra1 == VGA_ADDR) ? r_vga : regs[ra1];
        rd2 = (ra2 == VGA_ADDR) ? r_vga : regs[ra2];
    end
endmodule

// File: tb/tb_reg_bank.sv
module tb_reg_bank;
    logic        clk;
    logic        rst;
    logic        we3;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  wa3;
    logic [127:0] wev;
    logic [31:0] wd3;
    logic [31:0] r_vga;
    logic [31:0] rd1;
    logic [31:0] rd2;

    reg_bank dut (
        .clk(clk), .rst(rst), .we3(we3), .ra1(ra1), .ra2(ra2), .wa3(wa3),
        .wev(wev), .wd3(wd3), .r_vga(r_vga), .rd1(rd1), .rd2(rd2)
    );

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t q[$];
    event present;
    int   n_vec;
    int   n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: whenever the stimulus signals that outputs are settled, drain
    // the scoreboard and compare against the live DUT outputs.
    initial begin
        forever begin
            @(present);
            while (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                n_vec++;
                if (rd1 !== e.e1) begin
                    n_bad++;
                    $display("FAIL %s rd1: got %h want %h", e.name, rd1, e.e1);
                end
                n_vec++;
                if (rd2 !== e.e2) begin
                    n_bad++;
                    $display("FAIL %s rd2: got %h want %h", e.name, rd2, e.e2);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        e.name = nm;
        e.e1 = e1;
        e.e2 = e2;
        q.push_back(e);
        #1;
        -> present;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        we3 = 1'b1;
        wa3 = a;
        wd3 = d;
        tick();
        we3 = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1; we3 = 1'b0; ra1 = 4'd0; ra2 = 4'd0; wa3 = 4'd0;
        wev = '0; wd3 = '0; r_vga = '0;

        // Reset state before any clock edge
        chk("rst_addr0", 32'h0, 32'h0);
        ra1 = 4'd1; ra2 = 4'd1;
        chk("rst_addr1", 32'h0, 32'h0);

        // Write attempted while rst held is blocked; 15 reads r_vga
        ra1 = 4'd0; ra2 = 4'd15;
        wr(4'd0, 32'hFF);
        chk("rst_blocks_write", 32'h0, 32'h0);
        rst = 1'b0;

        // Basic write
        wr(4'd0, 32'h0000_00FF);
        ra1 = 4'd0; ra2 = 4'd1;
        chk("write_r0", 32'h0000_00FF, 32'h0);

        // we3=0 to address 15: nothing changes
        we3 = 1'b0; wa3 = 4'd15; wd3 = 32'hFF;
        tick();
        ra1 = 4'd0; ra2 = 4'd15;
        chk("we0_no_change", 32'h0000_00FF, 32'h0);

        // Write to address 15 is discarded
        wr(4'd15, 32'hAAAA_5555);
        chk("wr15_discard", 32'h0000_00FF, 32'h0);
        for (int i = 1; i < 15; i++) begin
            ra1 = 4'(i); ra2 = 4'(i);
            chk("wr15_others", 32'h0, 32'h0);
        end

        // Read-during-write: old value before the edge, new after
        ra1 = 4'd3; ra2 = 4'd3;
        we3 = 1'b1; wa3 = 4'd3; wd3 = 32'h3333_3333;
        chk("rdw_old", 32'h0, 32'h0);
        tick();
        we3 = 1'b0;
        chk("rdw_new", 32'h3333_3333, 32'h3333_3333);

        // r_vga propagates combinationally
        ra2 = 4'd15;
        r_vga = 32'hDEAD_BEEF;
        chk("vga_comb", 32'h3333_3333, 32'hDEAD_BEEF);

        // R14 write, wev ignored, async reset clears immediately
        wr(4'd14, 32'h1234_5678);
        ra1 = 4'd14;
        chk("r14_write", 32'h1234_5678, 32'hDEAD_BEEF);
        wev = '1;
        chk("wev_ignored", 32'h1234_5678, 32'hDEAD_BEEF);
        #2;
        rst = 1'b1;
        chk("async_rst", 32'h0, 32'hDEAD_BEEF);

        // Reset on the same edge as a write wins
        wr(4'd14, 32'h5A5A_5A5A);
        chk("rst_wins", 32'h0, 32'hDEAD_BEEF);
        rst = 1'b0;

        // First write after reset release is normal
        wr(4'd14, 32'h0000_0005);
        chk("post_rst_write", 32'h0000_0005, 32'hDEAD_BEEF);

        // Fill all registers with address+1 and read back on both ports
        for (int i = 0; i < 15; i++) begin
            wr(4'(i), 32'(i + 1));
        end
        for (int i = 0; i < 15; i++) begin
            ra1 = 4'(i); ra2 = 4'(14 - i);
            chk("fill_read", 32'(i + 1), 32'(15 - i));
        end
        ra1 = 4'd15; ra2 = 4'd15;
        r_vga = 32'hCAFE_F00D;
        chk("fill_vga", 32'hCAFE_F00D, 32'hCAFE_F00D);

        #2;
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
